// File: rtl/brams_linebuf_nch.sv
// Multi-channel rotating line buffer: ROWS x CH single-port banks, one output column per accepted pixel.
// Optional top zero padding with out_valid from the first frame row: define LINEBUF_ZEROPAD_EN.
module brams_linebuf_nch #(
  parameter int BD      = 18,
  parameter int CH      = 3,
  parameter int ROWS    = 4,
  parameter int ROW_LEN = 14,
  parameter int AW      = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sof,
  input  logic                   in_valid,
  input  logic [BD*CH-1:0]       d,
  output logic                   out_valid,
  output logic [AW-1:0]          out_col,
  output logic [BD*CH*ROWS-1:0]  q,
  output logic                   row_done,
  output logic                   frame_err
);

  localparam int PW = BD * CH;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [AW-1:0] col_cnt;
  logic [RW-1:0] wr_row;
  logic [RW-1:0] fill_cnt;

  logic          accept;
  logic          frame_start;
  logic          last_col;
  logic [AW-1:0] col_eff;
  logic [RW-1:0] row_eff;
  logic [RW-1:0] fill_eff;

  logic [RW-1:0] row_q;
  logic [PW-1:0] d_q;
  logic [BD-1:0] rd [ROWS][CH];
`ifdef LINEBUF_ZEROPAD_EN
  logic [RW-1:0] fill_q;
`endif

  // A sof pixel restarts the frame before its own write, so every index below uses the *_eff view.
  always_comb begin
    accept      = in_valid;
    frame_start = in_valid & sof;
    col_eff     = frame_start ? '0 : col_cnt;
    row_eff     = frame_start ? '0 : wr_row;
    fill_eff    = frame_start ? '0 : fill_cnt;
    last_col    = (col_eff == AW'(ROW_LEN - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col_cnt   <= '0;
      wr_row    <= '0;
      fill_cnt  <= '0;
      frame_err <= 1'b0;
    end else if (accept) begin
      frame_err <= frame_err | (frame_start && (col_cnt != '0));
      if (last_col) begin
        col_cnt  <= '0;
        wr_row   <= (row_eff == RW'(ROWS - 1)) ? '0 : row_eff + 1'b1;
        fill_cnt <= (fill_eff == RW'(ROWS - 1)) ? fill_eff : fill_eff + 1'b1;
      end else begin
        col_cnt  <= col_eff + 1'b1;
        wr_row   <= row_eff;
        fill_cnt <= fill_eff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      row_done  <= 1'b0;
      out_col   <= '0;
      row_q     <= '0;
      d_q       <= '0;
`ifdef LINEBUF_ZEROPAD_EN
      fill_q    <= '0;
`endif
    end else begin
`ifdef LINEBUF_ZEROPAD_EN
      out_valid <= accept;
`else
      out_valid <= accept && (fill_eff == RW'(ROWS - 1));
`endif
      row_done  <= accept && last_col;
      if (accept) begin
        out_col <= col_eff;
        row_q   <= row_eff;
        d_q     <= d;
`ifdef LINEBUF_ZEROPAD_EN
        fill_q  <= fill_eff;
`endif
      end
    end
  end

  for (genvar b = 0; b < ROWS; b++) begin : g_bank
    for (genvar c = 0; c < CH; c++) begin : g_ch
      logic [BD-1:0] mem [2**AW];

      // NOTE: the array has no reset so it maps onto block RAM; only the read register is cleared.
      always_ff @(posedge clk) begin
        if (reset && accept && (row_eff == RW'(b)))
          mem[col_eff] <= d[(CH-1-c)*BD +: BD];
      end

      // NOTE: non-blocking read and write in the same edge yields the old word on an address collision.
      always_ff @(posedge clk) begin
        if (!reset)
          rd[b][c] <= '0;
        else if (accept)
          rd[b][c] <= mem[col_eff];
      end
    end
  end

  // Slot k (oldest first) comes from bank row_q+1+k; the newest slot is the bypassed pixel.
  always_comb begin
    logic [RW-1:0] bsel;
    q    = '0;
    bsel = '0;
    for (int k = 0; k < ROWS - 1; k++) begin
      bsel = RW'((int'(row_q) + 1 + k) % ROWS);
`ifdef LINEBUF_ZEROPAD_EN
      if (k >= ROWS - 1 - int'(fill_q)) begin
        for (int c = 0; c < CH; c++)
          q[(ROWS-1-k)*PW + (CH-1-c)*BD +: BD] = rd[bsel][c];
      end
`else
      for (int c = 0; c < CH; c++)
        q[(ROWS-1-k)*PW + (CH-1-c)*BD +: BD] = rd[bsel][c];
`endif
    end
    q[PW-1:0] = d_q;
  end

endmodule

// File: tb/tb_brams_linebuf_nch.sv
// Directed bench for brams_linebuf_nch; pixels carry {frame,row,col,channel} tags so each q slot is traceable.
module tb_brams_linebuf_nch;
  localparam int BD = 18, CH = 3, ROWS = 4, ROW_LEN = 14, AW = 10;
  localparam int PW = BD * CH;
  localparam int QW = PW * ROWS;

  logic          clk = 1'b0;
  logic          reset, sof, in_valid;
  logic [PW-1:0] d;
  logic          out_valid, row_done, frame_err;
  logic [AW-1:0] out_col;
  logic [QW-1:0] q;

  int errors = 0;
  int checks = 0;

  brams_linebuf_nch #(.BD(BD), .CH(CH), .ROWS(ROWS), .ROW_LEN(ROW_LEN), .AW(AW)) dut (
    .clk(clk), .reset(reset), .sof(sof), .in_valid(in_valid), .d(d),
    .out_valid(out_valid), .out_col(out_col), .q(q), .row_done(row_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [QW-1:0] obs, input logic [QW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] pix(input int f, input int r, input int c);
    logic [PW-1:0] p;
    for (int ch = 0; ch < CH; ch++)
      p[(CH-1-ch)*BD +: BD] = BD'((f << 12) | (r << 8) | (c << 2) | ch);
    return p;
  endfunction

  // Column ending at row r_new; rows before the frame start read as zero.
  function automatic logic [QW-1:0] col_exp(input int f, input int r_new, input int c);
    logic [QW-1:0] v;
    int row;
    v = '0;
    for (int k = 0; k < ROWS; k++) begin
      row = r_new - (ROWS - 1) + k;
      if (row >= 0) v[(ROWS-1-k)*PW +: PW] = pix(f, row, c);
    end
    return v;
  endfunction

  task automatic step(input logic v, input logic s, input logic [PW-1:0] data);
    in_valid = v;
    sof      = s;
    d        = data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [QW-1:0] last_q;
    logic [AW-1:0] last_c;
    bit            have_last;
    reset = 1'b0; sof = 1'b0; in_valid = 1'b0; d = '0;

    // Reset held with traffic present
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, pix(0, 9, i));
      check("rst_vld",  out_valid, 0);
      check("rst_q",    q, 0);
      check("rst_done", row_done, 0);
      check("rst_err",  frame_err, 0);
      check("rst_col",  out_col, 0);
    end
    reset = 1'b1;

`ifndef LINEBUF_ZEROPAD_EN
    // One row after reset: row_done pulses, no output column yet
    for (int c = 0; c < ROW_LEN; c++) begin
      step(1'b1, 1'b0, pix(0, 9, c));
      check("r0_vld",  out_valid, 0);
      check("r0_done", row_done, (c == ROW_LEN - 1));
    end
    step(1'b0, 1'b0, '0);
    check("r0_done_off", row_done, 0);

    // Fill from sof, then rotate through rows 4 and 5
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < ROW_LEN; c++) begin
        step(1'b1, (r == 0 && c == 0), pix(0, r, c));
        check("fill_vld",  out_valid, (r >= ROWS - 1));
        check("fill_done", row_done, (c == ROW_LEN - 1));
        if (r >= ROWS - 1) begin
          check("fill_q",   q, col_exp(0, r, c));
          check("fill_col", out_col, c);
        end
      end
    end
    check("fill_err", frame_err, 0);

    // Random input gaps during rows 3-4 of a new frame
    have_last = 0;
    last_q = '0;
    last_c = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < ROW_LEN; c++) begin
        if (r >= 3) begin
          for (int g = 0; g < 3 && $urandom_range(0, 9) < 3; g++) begin
            step(1'b0, 1'b0, '0);
            check("gap_vld",  out_valid, 0);
            check("gap_done", row_done, 0);
            if (have_last) begin
              check("gap_qhold",   q, last_q);
              check("gap_colhold", out_col, last_c);
            end
          end
        end
        step(1'b1, (r == 0 && c == 0), pix(1, r, c));
        check("gap_pvld", out_valid, (r >= ROWS - 1));
        if (r >= ROWS - 1) begin
          last_q = col_exp(1, r, c);
          last_c = AW'(c);
          have_last = 1;
          check("gap_q",   q, last_q);
          check("gap_col", out_col, last_c);
        end
      end
    end

    // Aborted frame: sof arrives at row 1 col 6
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < ((r == 0) ? ROW_LEN : 6); c++)
        step(1'b1, (r == 0 && c == 0), pix(2, r, c));
    check("abort_err_pre", frame_err, 0);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < ROW_LEN; c++) begin
        step(1'b1, (r == 0 && c == 0), pix(3, r, c));
        check("abort_err", frame_err, 1);
        check("abort_vld", out_valid, (r == ROWS - 1));
        if (r == ROWS - 1) begin
          check("abort_q",   q, col_exp(3, r, c));
          check("abort_col", out_col, c);
        end
      end
    end
    step(1'b0, 1'b0, '0);
    check("abort_err_sticky", frame_err, 1);
    check("idle_vld", out_valid, 0);
`else
    // Zero-padded frame start: columns appear from the first pixel
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < ROW_LEN; c++) begin
        step(1'b1, (r == 0 && c == 0), pix(0, r, c));
        check("zp_vld",  out_valid, 1);
        check("zp_q",    q, col_exp(0, r, c));
        check("zp_col",  out_col, c);
        check("zp_done", row_done, (c == ROW_LEN - 1));
      end
    end
    step(1'b0, 1'b0, '0);
    check("zp_idle_vld", out_valid, 0);
    check("zp_err", frame_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/brams_linebuf_nch.md
Name: brams_linebuf_nch

Overview:
- Parametrised multi-channel line buffer between a pooling stage and the next convolution stage.
- Accepts a raster pixel stream of CH channels and stores it in ROWS rotating row banks.
- Each accepted pixel produces a vertical column of ROWS pixels (all channels), oldest row first, for the downstream conv window.
- Generalises the fixed 4-bank x 3-channel store: owns its own write addressing, row rotation, fill tracking and output alignment.

Parameters:
- BD, 18: bits per channel sample.
- CH, 3: channels per pixel.
- ROWS, 4: row banks; output column height (>=2).
- ROW_LEN, 14: pixels per image row (<= 2**AW).
- AW, 10: bank address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-low reset.
- sof  in  1  start of frame; qualified by in_valid; marks the first pixel of a frame.
- in_valid  in  1  pixel strobe.
- d  in  BD*CH  pixel; channel 0 in MSBs.
- out_valid  out  1  q/out_col valid.
- out_col  out  AW  column index of the current q.
- q  out  BD*CH*ROWS  column; slot 0 (MSBs) = oldest row, slot ROWS-1 = newest row.
- row_done  out  1  one-cycle pulse with the last column of each row.
- frame_err  out  1  sticky; set when sof arrives while col_cnt != 0. Cleared by reset.

Behaviour:
- Reset (reset==0 at a clk edge):
  - col_cnt=0, wr_row=0, fill_cnt=0.
  - out_valid=0, out_col=0, q=0, row_done=0, frame_err=0.
  - Bank contents are not cleared.
- Banks: ROWS x CH memories, each 2**AW x BD, single port, read-old-data on same-address write.
- Accepted pixel (in_valid==1):
  - Write d to bank wr_row at address col_cnt.
  - Read all banks at address col_cnt in the same cycle.
- Latency = 1 cycle; q and out_valid are registered.
  - The newest slot takes d bypassed through a register, not the bank read.
  - Older slots map rotationally: slot k (k<ROWS-1) = bank (wr_row+1+k) mod ROWS.
- Counters:
  - col_cnt increments per accepted pixel.
  - At ROW_LEN-1: col_cnt wraps to 0, wr_row = (wr_row+1) mod ROWS, fill_cnt saturates at ROWS-1.
- out_valid = 1 one cycle after an accepted pixel only when fill_cnt==ROWS-1 at acceptance; otherwise 0.
- out_col = col_cnt at acceptance, registered.
- row_done = 1 one cycle after the acceptance where col_cnt==ROW_LEN-1, regardless of fill_cnt.
- in_valid==0: no write, counters hold, out_valid and row_done deassert next cycle, q holds.
- sof with in_valid: the pixel is treated as column 0 of a new frame:
  - col_cnt forced to 0, wr_row=0, fill_cnt=0 before the write.
  - If col_cnt was nonzero, frame_err is set.
  - The pixel is written to bank 0 address 0.
- Boundary cases:
  - Back-to-back full-rate input: no bubbles.
  - Row wrap and fill saturation occur on the same edge as the write.
  - A reset assertion mid-row discards state; the next frame must begin with sof or col 0.
  - ROWS-1 full rows must be received before the first out_valid.
  - Arithmetic is indices only; data passes unmodified.

Optional Feature:
- Macro: LINEBUF_ZEROPAD_EN.
- Defined:
  - out_valid asserts from the first row of a frame.
  - Slots holding rows not yet written in this frame (slot index < ROWS-1-fill_cnt) output zero, giving top zero padding.
  - A row_done on the last frame row is unaffected.
- Undefined: behaviour exactly as above; no padding logic is generated.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_valid=1 -> all outputs 0, no out_valid; release, feed 14 pixels -> row_done single pulse one cycle after pixel 13, out_valid stays 0.
- Fill: sof + 4 rows of d = {row,col,ch} tags, full rate -> first out_valid one cycle after row 3 col 0; q slots = rows 0,1,2,3 at col 0; out_col sequence 0..13.
- Rotation: continue to row 5 -> at row 5 col 7, q slots = rows 2,3,4,5 col 7; checks the bank wrap.
- Gaps: random in_valid deassertion (30%) during rows 3-4 -> identical q/out_col sequence to the full-rate run, q held during gaps.
- Mid-row sof: sof at row 1 col 6 -> frame_err=1 sticky, counters restart; out_valid first seen after 3 new full rows + 1 pixel.
- ZEROPAD (macro defined): sof, row 0 col 0 -> out_valid one cycle later, slots 0-2 = 0, slot 3 = pixel (0,0).
